cb_zigzag_serializer: RTL and testbench

//  Consumer end of the Cb DCT output interface. Captures one 8x8 block of 11-bit signed

---
 rtl/jpeg_zz_pkg.sv | 32 +++
 rtl/zz_last_nz_finder.sv | 27 ++
 rtl/cb_zigzag_serializer.sv | 164 ++++++++++++++++
 tb/tb_cb_zigzag_serializer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_zz_pkg.sv
// ============================================================================
// Module : jpeg_zz_pkg
// Brief  : Shared types and the JPEG zigzag lookup table for the Cb serializer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package jpeg_zz_pkg;

  localparam int COEF_W = 11;
  localparam int BLK_N  = 64;
  localparam int IDX_W  = 6;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t                    blk_t [BLK_N];
  typedef logic [IDX_W-1:0]         idx_t;

  // Row-major coefficient index for each zigzag position.
  localparam idx_t ZIGZAG [BLK_N] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

`default_nettype wire

// File: rtl/zz_last_nz_finder.sv
// ============================================================================
// Module : zz_last_nz_finder
// Brief  : Combinational scan giving the highest zigzag position holding a
//          nonzero coefficient (0 when the whole block is zero).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module zz_last_nz_finder
  import jpeg_zz_pkg::*;
(
  input  blk_t i_blk,
  output idx_t o_last_k
);

  always_comb begin
    o_last_k = '0;
    for (int i = 0; i < BLK_N; i++) begin
      if (i_blk[ZIGZAG[i]] != '0) begin
        o_last_k = idx_t'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cb_zigzag_serializer.sv
// ============================================================================
// Module : cb_zigzag_serializer
// Brief  : Captures 8x8 Cb coefficient blocks into a ping-pong buffer and
//          streams them out in zigzag order over valid/ready.
//          Define CB_ZZ_EOB_EN to truncate each block after its last nonzero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cb_zigzag_serializer
  import jpeg_zz_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [BLK_N*COEF_W-1:0] coef_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COEF_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    overflow
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0] r_state;
  blk_t       r_buf [2];
  logic [1:0] r_full;
  logic       r_wr_ptr;
  logic       r_rd_ptr;

  blk_t       w_blk;
  logic [1:0] w_full_nxt;
  logic       w_hs;
  logic       w_last_hs;
  logic       w_cap;
  logic       w_load;
  logic       w_go_idle;
  logic       w_sel;
  logic       w_other;
  idx_t       w_k_nxt;
  idx_t       w_sel_last_k;

  always_comb begin
    for (int i = 0; i < BLK_N; i++) begin
      w_blk[i] = coef_in[i*COEF_W +: COEF_W];
    end
  end

  assign w_hs      = out_valid & out_ready;
  assign w_last_hs = w_hs & out_last;
  assign w_other   = ~r_rd_ptr;
  // A slot drained by this cycle's final handshake is reusable on the same edge.
  assign w_cap     = in_valid & (~r_full[r_wr_ptr] | (w_last_hs & (r_rd_ptr == r_wr_ptr)));

`ifdef CB_ZZ_EOB_EN
  idx_t r_last_k [2];
  idx_t w_blk_last_k;

  zz_last_nz_finder u_finder (
    .i_blk    (w_blk),
    .o_last_k (w_blk_last_k)
  );

  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_last_k[r_wr_ptr] <= w_blk_last_k;
    end
  end

  assign w_sel_last_k = r_last_k[w_sel];
`else
  assign w_sel_last_k = idx_t'(BLK_N - 1);
`endif

  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_buf[r_wr_ptr] <= w_blk;
    end
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_last_hs) begin
      w_full_nxt[r_rd_ptr] = 1'b0;
    end
    if (w_cap) begin
      w_full_nxt[r_wr_ptr] = 1'b1;
    end
  end

  // Decide which beat (buffer, position) gets loaded into the output registers.
  always_comb begin
    w_load    = 1'b0;
    w_go_idle = 1'b0;
    w_sel     = r_rd_ptr;
    w_k_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        w_load = r_full[r_rd_ptr];
      end
      S_STREAM: begin
        if (w_hs) begin
          if (out_last) begin
            if (r_full[w_other]) begin
              w_load = 1'b1;
              w_sel  = w_other;
            end else begin
              w_go_idle = 1'b1;
            end
          end else begin
            w_load  = 1'b1;
            w_k_nxt = out_index + 1'b1;
          end
        end
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_full    <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (in_valid && !w_cap) begin
        overflow <= 1'b1;
      end
      if (w_cap) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_last_hs) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_load) begin
        r_state   <= S_STREAM;
        out_valid <= 1'b1;
        out_data  <= r_buf[w_sel][ZIGZAG[w_k_nxt]];
        out_index <= w_k_nxt;
        out_last  <= (w_k_nxt == w_sel_last_k);
      end else if (w_go_idle) begin
        r_state   <= S_IDLE;
        out_valid <= 1'b0;
        out_index <= '0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cb_zigzag_serializer.sv
// ============================================================================
// Module : tb_cb_zigzag_serializer
// Brief  : Self-checking bench with a queue-based block model for the serializer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cb_zigzag_serializer;

  localparam int CW = 11;
  localparam int BN = 64;
  localparam int FW = CW * BN;
  typedef logic [FW-1:0] flat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  flat_t         coef_in = '0;
  logic          out_valid;
  logic [CW-1:0] out_data;
  logic [5:0]    out_index;
  logic          out_last;
  logic          overflow;

  cb_zigzag_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .coef_in   (coef_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  int     zz [BN];

  // Model: blocks accepted but not yet fully handshaken, oldest first.
  flat_t  mq [$];
  int     mlen [$];
  int     mpos = 0;
  bit     m_ovf = 1'b0;
  int     m_acc_beats = 0;
  flat_t  cf;

  logic [CW-1:0] lg_data [$];
  int            lg_idx [$];
  bit            lg_last [$];
  longint        lg_cyc [$];

  int rmode = 0;
  bit rfix = 1'b1;
  int stall_left = 0;
  bit stall_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int blk_len(input flat_t b);
    int l = 1;
    for (int p = 0; p < BN; p++) begin
      if (b[zz[p]*CW +: CW] != '0) l = p + 1;
    end
`ifdef CB_ZZ_EOB_EN
    return l;
`else
    return (l > 0) ? BN : BN;
`endif
  endfunction

  function automatic flat_t rand_blk(input bit force_last);
    flat_t b = '0;
    int cut = $urandom_range(0, 63);
    int sel = $urandom_range(0, 4);
    for (int p = 0; p < BN; p++) begin
      if (p <= cut && $urandom_range(0, 2) != 0) b[zz[p]*CW +: CW] = CW'($urandom);
    end
    if (sel == 0) b = '0;
    if (force_last) b[63*CW +: CW] = CW'($urandom_range(1, 2047));
    return b;
  endfunction

  function automatic flat_t ramp_blk();
    flat_t b = '0;
    for (int i = 0; i < BN; i++) b[i*CW +: CW] = CW'(i);
    return b;
  endfunction

  initial begin
    int n = 0;
    for (int s = 0; s <= 14; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz[n] = r * 8 + (s - r); n++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz[n] = r * 8 + (s - r); n++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      mq.delete(); mlen.delete(); mpos = 0; m_ovf = 1'b0;
    end else begin
      chk("overflow", overflow, m_ovf);
      if (out_valid) begin
        if (mq.size() == 0) begin
          chk("spurious_valid", out_valid, 0);
        end else begin
          cf = mq[0];
          chk("data", out_data, cf[zz[mpos]*CW +: CW]);
          chk("index", out_index, mpos);
          chk("last", out_last, (mpos == mlen[0] - 1));
        end
      end
      if (out_valid && out_ready && mq.size() > 0) begin
        lg_data.push_back(out_data); lg_idx.push_back(out_index);
        lg_last.push_back(out_last); lg_cyc.push_back(cyc);
        mpos++;
        if (mpos == mlen[0]) begin
          void'(mq.pop_front()); void'(mlen.pop_front()); mpos = 0;
        end
      end
      if (in_valid) begin
        if (mq.size() < 2) begin
          mq.push_back(coef_in); mlen.push_back(blk_len(coef_in));
          m_acc_beats += blk_len(coef_in);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rmode == 0) begin
        out_ready = rfix;
      end else if (rmode == 1) begin
        out_ready = ($urandom_range(0, 99) < 70);
      end else begin
        if (stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
          chk("stall_index", out_index, 20); chk("stall_data", out_data, 40);
        end else if (!stall_done && out_valid && out_index == 6'd20) begin
          stall_done = 1'b1; stall_left = 4; out_ready = 1'b0;
          chk("stall_index", out_index, 20); chk("stall_data", out_data, 40);
        end else begin
          out_ready = ~out_ready;
        end
      end
    end
  end

  task automatic send_block(input flat_t b);
    @(posedge clk); #1;
    coef_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk); #2;
      if (mq.size() == 0 && !out_valid) ok = 1'b1;
    end
    chk(nm, ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lg_data.delete(); lg_idx.delete(); lg_last.delete(); lg_cyc.delete();
    m_acc_beats = 0;
  endtask

  initial begin
    flat_t a, b, c;
    int exp_len, nz, breaks;
    bit found;
    #12;
    chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0); chk("rst_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    do_reset();

    // Ramp: zigzag order and latency
    rmode = 0; rfix = 1'b1;
    repeat (2) @(posedge clk);
    send_block(ramp_blk());
    chk("lat_valid_cap", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid_next", out_valid, 1);
    chk("lat_index0", out_index, 0);
    drain(500, "ramp_drain");
    chk("ramp_beats", lg_data.size(), 64);
    if (lg_data.size() == 64) begin
      chk("ramp_d1", lg_data[1], 1); chk("ramp_d2", lg_data[2], 8);
      chk("ramp_d3", lg_data[3], 16); chk("ramp_d4", lg_data[4], 9);
      chk("ramp_d5", lg_data[5], 2); chk("ramp_d63", lg_data[63], 63);
      chk("ramp_i63", lg_idx[63], 63); chk("ramp_last63", lg_last[63], 1);
      chk("ramp_last62", lg_last[62], 0);
    end

    // Constant DC block, -1024 in 11 bits
    do_reset();
    a = '0; a[0 +: CW] = 11'h400;
`ifdef CB_ZZ_EOB_EN
    exp_len = 1;
`else
    exp_len = 64;
`endif
    send_block(a);
    drain(500, "dc_drain");
    chk("dc_beats", lg_data.size(), exp_len);
    if (lg_data.size() > 0) begin
      chk("dc_data0", lg_data[0], 11'h400);
      chk("dc_last", lg_last[lg_last.size()-1], 1);
      nz = 0;
      foreach (lg_data[i]) if (lg_data[i] != '0) nz++;
      chk("dc_nonzero", nz, 1);
    end

    // Back-pressure with a 5-cycle stall at index 20
    do_reset();
    stall_done = 1'b0; stall_left = 0; rmode = 2;
    send_block(ramp_blk());
    drain(1000, "bp_drain");
    chk("bp_beats", lg_data.size(), 64);
    chk("bp_stall_seen", stall_done, 1);
    rmode = 0; rfix = 1'b1;

    // Back-to-back blocks 64 cycles apart
    do_reset();
    repeat (2) @(posedge clk);
    a = rand_blk(1'b1); b = rand_blk(1'b1);
    send_block(a);
    repeat (62) @(posedge clk);
    send_block(b);
    drain(1000, "b2b_drain");
    chk("b2b_beats", lg_data.size(), 128);
    breaks = 0;
    for (int i = 1; i < lg_cyc.size(); i++) if (lg_cyc[i] != lg_cyc[i-1] + 1) breaks++;
    chk("b2b_bubbles", breaks, 0);
    chk("b2b_overflow", overflow, 0);

    // Overflow: third block dropped while ready is low
    do_reset();
    rfix = 1'b0;
    repeat (2) @(posedge clk);
    a = rand_blk(1'b1); b = rand_blk(1'b1); c = rand_blk(1'b1);
    send_block(a);
    repeat (8) @(posedge clk);
    send_block(b);
    chk("ovf_before", overflow, 0);
    repeat (8) @(posedge clk);
    send_block(c);
    chk("ovf_after", overflow, 1);
    rfix = 1'b1;
    drain(1000, "ovf_drain");
    chk("ovf_beats", lg_data.size(), 128);
    if (lg_data.size() == 128) begin
      chk("ovf_a0", lg_data[0], a[0 +: CW]);
      chk("ovf_b0", lg_data[64], b[0 +: CW]);
    end
    chk("ovf_sticky", overflow, 1);

    // Asynchronous reset mid-stream
    do_reset();
    send_block(ramp_blk());
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_index == 6'd30) found = 1'b1;
    end
    chk("arst_reach30", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0); chk("arst_data", out_data, 0);
    chk("arst_index", out_index, 0); chk("arst_last", out_last, 0);
    chk("arst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lg_data.delete(); lg_idx.delete(); lg_last.delete(); lg_cyc.delete();
    a = rand_blk(1'b0);
    send_block(a);
    drain(500, "arst_drain");
    chk("arst_beats", lg_data.size(), blk_len(a));
    if (lg_idx.size() > 0) chk("arst_first_idx", lg_idx[0], 0);

    // Randomized traffic with random ready and gaps
    do_reset();
    rmode = 1;
    for (int n = 0; n < 25; n++) begin
      send_block(rand_blk($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 90)) @(posedge clk);
    end
    drain(5000, "rand_drain");
    chk("rand_beats", lg_data.size(), m_acc_beats);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
